// File: rtl/spi_slave_frame.sv
// Oversampled full-duplex SPI slave with runtime frame length (1..MAX_BYTES bytes) and early-CSEL detection.
// Define SPI_SLV_CRC8_EN to add a CRC-8 check of the last received byte (crc_err output).
module spi_slave_frame #(
  parameter  int MAX_BYTES   = 6,
  parameter  int SAMPLE_EDGE = 0,
  parameter  int SYNC_STAGES = 2,
  localparam int DW          = 8 * MAX_BYTES,
  localparam int BCW         = $clog2(MAX_BYTES + 1),
  localparam int CW          = $clog2(DW + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           SCK,
  input  logic           MOSI,
  input  logic           CSEL,
  output logic           MISO,
  input  logic [BCW-1:0] frame_bytes,
  input  logic [DW-1:0]  tx_data,
  output logic           busy,
  output logic [DW-1:0]  rx_data,
  output logic [BCW-1:0] rx_bytes,
  output logic           rx_valid,
  output logic           frame_err
`ifdef SPI_SLV_CRC8_EN
  ,
  output logic           crc_err
`endif
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  // Synchronisers carry no reset so RST cannot fabricate a CSEL fall while the pin is already low.
  logic [SYNC_STAGES-1:0] sck_sync, csel_sync, mosi_sync;
  logic                   sck_prev, csel_prev;
  logic                   sck_s, csel_s, mosi_s;
  logic                   sck_rise, sck_fall, csel_rise, csel_fall;
  logic                   sample_ev, shift_ev;

  always_ff @(posedge CLK) begin
    sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
    csel_sync <= {csel_sync[SYNC_STAGES-2:0], CSEL};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    sck_prev  <= sck_sync[SYNC_STAGES-1];
    csel_prev <= csel_sync[SYNC_STAGES-1];
  end

  assign sck_s     = sck_sync[SYNC_STAGES-1];
  assign csel_s    = csel_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev;
  assign sck_fall  = ~sck_s & sck_prev;
  assign csel_rise = csel_s & ~csel_prev;
  assign csel_fall = ~csel_s & csel_prev;
  assign sample_ev = (SAMPLE_EDGE != 0) ? sck_rise : sck_fall;
  assign shift_ev  = (SAMPLE_EDGE != 0) ? sck_fall : sck_rise;

  state_t          state;
  logic [BCW-1:0]  n_cur;
  logic [CW-1:0]   nbits, bit_cnt;
  logic [DW-2:0]   rx_sr;
  logic [DW-1:0]   tx_sr;

  logic [BCW-1:0]  n_in;
  logic [CW-1:0]   nbits_in, cnt_next;
  logic [DW-1:0]   tx_aligned, rx_next, rx_mask;
  logic            last_bit;

  // Out-of-range lengths fall back to a full-width frame.
  assign n_in       = (frame_bytes == '0 || frame_bytes > BCW'(MAX_BYTES)) ? BCW'(MAX_BYTES) : frame_bytes;
  assign nbits_in   = CW'(n_in) << 3;
  assign tx_aligned = tx_data << (CW'(DW) - nbits_in);
  assign rx_next    = {rx_sr, mosi_s};
  assign rx_mask    = {DW{1'b1}} >> (CW'(DW) - nbits);
  assign cnt_next   = bit_cnt + CW'(1);
  assign last_bit   = sample_ev && (cnt_next == nbits);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      MISO      <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= '0;
      rx_bytes  <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      n_cur     <= '0;
      nbits     <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          MISO <= 1'b0;
          busy <= 1'b0;
          if (csel_fall) begin
            n_cur   <= n_in;
            nbits   <= nbits_in;
            tx_sr   <= tx_aligned;
            rx_sr   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            MISO    <= tx_aligned[DW-1];
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (sample_ev) begin
            rx_sr   <= rx_next[DW-2:0];
            bit_cnt <= cnt_next;
          end
          // A final sample wins over a coincident CSEL rise: the frame is complete.
          if (last_bit) begin
            rx_data  <= rx_next & rx_mask;
            rx_bytes <= n_cur;
            rx_valid <= 1'b1;
            MISO     <= 1'b0;
            if (csel_rise) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= HOLD;
            end
          end else if (csel_rise) begin
            frame_err <= 1'b1;
            busy      <= 1'b0;
            MISO      <= 1'b0;
            state     <= IDLE;
          end else if (shift_ev && bit_cnt != '0) begin
            // The first bit was pre-presented, so a shift edge before any sample must not advance.
            tx_sr <= tx_sr << 1;
            MISO  <= tx_sr[DW-2];
          end
        end
        HOLD: begin
          MISO <= 1'b0;
          if (csel_rise) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_SLV_CRC8_EN
  // Serial CRC-8 (poly 0x07) over all bytes but the last; compared with the last byte on completion.
  logic [7:0] crc;
  logic       crc_fb;

  assign crc_fb = crc[7] ^ mosi_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      crc     <= '0;
      crc_err <= 1'b0;
    end else if (state == IDLE && csel_fall) begin
      crc <= '0;
    end else if (state == SHIFT && sample_ev) begin
      if (bit_cnt < nbits - CW'(8))
        crc <= {crc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
      if (last_bit)
        crc_err <= (n_cur != BCW'(1)) && (rx_next[7:0] != crc);
    end
  end
`endif

endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame (MAX_BYTES=6, SAMPLE_EDGE=0): table of frames plus reset/CRC sequences.
module tb_spi_slave_frame;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        SCK = 1'b0;
  logic        MOSI = 1'b0;
  logic        CSEL = 1'b1;
  logic        MISO;
  logic [2:0]  frame_bytes = 3'd0;
  logic [47:0] tx_data = '0;
  logic        busy;
  logic [47:0] rx_data;
  logic [2:0]  rx_bytes;
  logic        rx_valid;
  logic        frame_err;
`ifdef SPI_SLV_CRC8_EN
  logic        crc_err;
`endif

  spi_slave_frame dut (
    .CLK(CLK), .RST(RST), .SCK(SCK), .MOSI(MOSI), .CSEL(CSEL), .MISO(MISO),
    .frame_bytes(frame_bytes), .tx_data(tx_data), .busy(busy),
    .rx_data(rx_data), .rx_bytes(rx_bytes), .rx_valid(rx_valid), .frame_err(frame_err)
`ifdef SPI_SLV_CRC8_EN
    , .crc_err(crc_err)
`endif
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [47:0] rx;
    logic [2:0]  bytes;
  } exp_t;
  exp_t sb[$];

  // Observed rx_valid events; only the monitor writes these.
  logic [47:0] obs_rx [0:63];
  logic [2:0]  obs_by [0:63];
  int          obs_cnt = 0;
  int          err_cnt = 0;
  int          obs_rd  = 0;

  always @(negedge CLK) begin
    if (rx_valid && obs_cnt < 64) begin
      obs_rx[obs_cnt] <= rx_data;
      obs_by[obs_cnt] <= rx_bytes;
      obs_cnt         <= obs_cnt + 1;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: bench still running, required to finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic drain_sb();
    exp_t e;
    while (obs_rd < obs_cnt) begin
      if (sb.size() == 0) begin
        check("unexpected_rx_valid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rx_data", {16'h0, obs_rx[obs_rd]}, {16'h0, e.rx});
        check("rx_bytes", {61'h0, obs_by[obs_rd]}, {61'h0, e.bytes});
      end
      obs_rd++;
    end
    check("rx_valid_missing", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  // One SPI bit, mode with SCK idle low: MOSI set after the fall, master samples MISO just before the fall.
  task automatic spi_bit(input logic b, input logic drop_cs, output logic m);
    repeat (2) @(negedge CLK);
    MOSI = b;
    repeat (3) @(negedge CLK);
    SCK = 1'b1;
    repeat (5) @(negedge CLK);
    m = MISO;
    SCK = 1'b0;
    if (drop_cs) CSEL = 1'b1;
  endtask

  task automatic spi_frame(input logic [63:0] word, input int nb, input logic cs_last,
                           output logic [63:0] miso_w);
    logic m;
    miso_w = '0;
    CSEL = 1'b0;
    repeat (6) @(negedge CLK);
    check("busy_set", {63'h0, busy}, 64'd1);
    // Late changes to the frame setup must not disturb the frame in flight.
    tx_data     = ~tx_data;
    frame_bytes = frame_bytes + 3'd1;
    for (int i = nb - 1; i >= 0; i--) begin
      spi_bit(word[i], cs_last && i == 0, m);
      miso_w = {miso_w[62:0], m};
    end
    if (!cs_last) begin
      repeat (4) @(negedge CLK);
      CSEL = 1'b1;
    end
    MOSI = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  n;
    int          nb;
    logic        cs_last;
    logic [47:0] mosi;
    logic [47:0] tx;
    logic        valid;
    logic [47:0] rx;
    logic [2:0]  bytes;
    logic [63:0] miso;
    int          err;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  initial begin
    vec_t        tv;
    logic [63:0] miso_w;
    logic [47:0] last_rx;
    int          err0, lat;
    logic        m;

    tbl[0] = '{3'd2, 16, 1'b0, 48'hA55A,         48'h1234,         1'b1, 48'hA55A,         3'd2, 64'h1234,         0};
    tbl[1] = '{3'd6, 48, 1'b0, 48'h010203040506, 48'hFFEEDDCCBBAA, 1'b1, 48'h010203040506, 3'd6, 64'hFFEEDDCCBBAA, 0};
    tbl[2] = '{3'd0, 48, 1'b0, 48'h123456789ABC, 48'h0F0E0D0C0B0A, 1'b1, 48'h123456789ABC, 3'd6, 64'h0F0E0D0C0B0A, 0};
    tbl[3] = '{3'd7, 48, 1'b0, 48'hCAFEBABE0001, 48'h800000000001, 1'b1, 48'hCAFEBABE0001, 3'd6, 64'h800000000001, 0};
    tbl[4] = '{3'd4, 32, 1'b0, 48'hDEADBEEF,     48'hAAAA76543210, 1'b1, 48'hDEADBEEF,     3'd4, 64'h76543210,     0};
    tbl[5] = '{3'd3, 13, 1'b0, 48'h1ABC,         48'h123456,       1'b0, 48'h0,            3'd0, 64'h246,          1};
    tbl[6] = '{3'd1, 12, 1'b0, 48'h5AF,          48'h1111111111A5, 1'b1, 48'h5A,           3'd1, 64'hA50,          0};
    tbl[7] = '{3'd2, 16, 1'b0, 48'h8001,         48'hC003,         1'b1, 48'h8001,         3'd2, 64'hC003,         0};
    tbl[8] = '{3'd1, 8,  1'b1, 48'h96,           48'h69,           1'b1, 48'h96,           3'd1, 64'h69,           0};
    tbl[9] = '{3'd5, 40, 1'b0, 48'h00FF00FF80,   48'h7F00FF0001,   1'b1, 48'h00FF00FF80,   3'd5, 64'h7F00FF0001,   0};

    RST = 1'b1;
    repeat (6) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_miso",      {63'h0, MISO},      64'd0);
    check("reset_busy",      {63'h0, busy},      64'd0);
    check("reset_rx_data",   {16'h0, rx_data},   64'd0);
    check("reset_rx_bytes",  {61'h0, rx_bytes},  64'd0);
    check("reset_rx_valid",  {63'h0, rx_valid},  64'd0);
    check("reset_frame_err", {63'h0, frame_err}, 64'd0);
`ifdef SPI_SLV_CRC8_EN
    check("reset_crc_err",   {63'h0, crc_err},   64'd0);
`endif
    last_rx = '0;

    for (int v = 0; v < NV; v++) begin
      tv          = tbl[v];
      tx_data     = tv.tx;
      frame_bytes = tv.n;
      if (tv.valid) sb.push_back('{tv.rx, tv.bytes});
      err0 = err_cnt;
      spi_frame({16'h0, tv.mosi}, tv.nb, tv.cs_last, miso_w);
      lat = 0;
      while (busy && lat < 10) begin
        @(negedge CLK);
        lat++;
      end
      check("busy_release_within_4", {63'h0, lat <= 4}, 64'd1);
      repeat (6) @(negedge CLK);
      drain_sb();
      check("miso_word", miso_w, tv.miso);
      check("frame_err_pulses", 64'(err_cnt - err0), 64'(tv.err));
      check("miso_idle", {63'h0, MISO}, 64'd0);
      if (tv.valid) last_rx = tv.rx;
      else check("rx_data_held", {16'h0, rx_data}, {16'h0, last_rx});
    end

    // Reset in the middle of a 2-byte frame while SCK keeps toggling.
    tx_data     = 48'h5555;
    frame_bytes = 3'd2;
    err0        = err_cnt;
    CSEL        = 1'b0;
    repeat (6) @(negedge CLK);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) RST = 1'b1;
      if (i == 8) RST = 1'b0;
      spi_bit(i[0], 1'b0, m);
    end
    repeat (4) @(negedge CLK);
    CSEL = 1'b1;
    repeat (10) @(negedge CLK);
    drain_sb();
    check("rst_abort_frame_err", 64'(err_cnt - err0), 64'd0);
    check("rst_abort_busy", {63'h0, busy}, 64'd0);
    check("rst_abort_rx_data", {16'h0, rx_data}, 64'd0);

    tx_data     = 48'h0F0F;
    frame_bytes = 3'd2;
    sb.push_back('{48'hBEEF, 3'd2});
    spi_frame(64'hBEEF, 16, 1'b0, miso_w);
    repeat (12) @(negedge CLK);
    drain_sb();
    check("after_rst_miso_word", miso_w, 64'h0F0F);

`ifdef SPI_SLV_CRC8_EN
    tx_data     = 48'hABCDEF;
    frame_bytes = 3'd3;
    sb.push_back('{48'h1234F1, 3'd3});
    spi_frame(64'h1234F1, 24, 1'b0, miso_w);
    repeat (12) @(negedge CLK);
    drain_sb();
    check("crc_good", {63'h0, crc_err}, 64'd0);
    check("crc_good_miso", miso_w, 64'hABCDEF);

    tx_data     = 48'h000000;
    frame_bytes = 3'd3;
    sb.push_back('{48'h123400, 3'd3});
    spi_frame(64'h123400, 24, 1'b0, miso_w);
    repeat (12) @(negedge CLK);
    drain_sb();
    check("crc_bad", {63'h0, crc_err}, 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
